// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, ALU, immediate and result-select encodings shared by the ID stage
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/regfile.sv
// regfile: 2R1W register file with async clear, hardwired x0 and optional write-through bypass
module regfile #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_hit1, w_hit2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        else if (i_we && i_wa != 5'd0)
            r_regs[i_wa] <= i_wd;
    end

    assign w_hit1 = (WB_BYPASS != 0) && i_we && i_wa == i_ra1;
    assign w_hit2 = (WB_BYPASS != 0) && i_we && i_wa == i_ra2;

    // reset gating keeps a pending W-stage write from leaking through the bypass
    assign o_rd1 = (!rst_n || i_ra1 == 5'd0) ? '0 : w_hit1 ? i_wd : r_regs[i_ra1];
    assign o_rd2 = (!rst_n || i_ra2 == 5'd0) ? '0 : w_hit2 ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage - control/ALU decode, immediate extension and register file
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic            ALUSrcD,
    output logic [1:0]      ResultSrcD,
    output logic [1:0]      ImmSrcD,
    output logic [2:0]      ALUControlD,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic [XLEN-1:0] ImmExtD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [4:0]      RdD,
    output logic            IllegalD
);

    ctrl_t       w_ctrl;
    logic        w_bad_op;
    logic        w_bad_fn;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [2:0]  w_fn_alu;

    assign w_op = InstrD[6:0];
    assign w_f3 = InstrD[14:12];
    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];
    assign RdD  = InstrD[11:7];

    always_comb begin
        w_bad_op = 1'b0;
        case (w_op)
            OP_LW:   w_ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALUOP_ADD, 1'b0};
            OP_SW:   w_ctrl = '{1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALUOP_ADD, 1'b0};
            OP_R:    w_ctrl = '{1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALUOP_FN,  1'b0};
            OP_BEQ:  w_ctrl = '{1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, ALUOP_SUB, 1'b0};
            OP_IALU: w_ctrl = '{1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, ALUOP_FN,  1'b0};
            OP_JAL:  w_ctrl = '{1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, ALUOP_ADD, 1'b1};
            default: begin
                w_ctrl   = '0;
                w_bad_op = 1'b1;
            end
        endcase
    end

    // subtract only for R-type with funct7[5]; addi's immediate bit 30 must not select sub
    assign w_fn_alu = w_f3 == 3'b000 ? ((w_op[5] & InstrD[30]) ? ALU_SUB : ALU_ADD) :
                      w_f3 == 3'b010 ? ALU_SLT :
                      w_f3 == 3'b110 ? ALU_OR  :
                      w_f3 == 3'b111 ? ALU_AND : ALU_ADD;

    assign w_bad_fn = w_ctrl.alu_op == ALUOP_FN &&
                      !(w_f3 == 3'b000 || w_f3 == 3'b010 || w_f3 == 3'b110 || w_f3 == 3'b111);

    assign ALUControlD = w_ctrl.alu_op == ALUOP_SUB ? ALU_SUB :
                         w_ctrl.alu_op == ALUOP_FN  ? w_fn_alu : ALU_ADD;

    assign RegWriteD  = w_ctrl.reg_write & ~w_bad_fn;
    assign MemWriteD  = w_ctrl.mem_write;
    assign JumpD      = w_ctrl.jump;
    assign BranchD    = w_ctrl.branch;
    assign ALUSrcD    = w_ctrl.alu_src;
    assign ResultSrcD = w_ctrl.result_src;
    assign ImmSrcD    = w_ctrl.imm_src;
    assign IllegalD   = w_bad_op | w_bad_fn;

    always_comb begin
        case (ImmSrcD)
            IMM_S:   ImmExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   ImmExtD = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   ImmExtD = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: ImmExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
        endcase
    end

    regfile #(
        .XLEN      (XLEN),
        .NREG      (NREG),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (Rs1D),
        .i_ra2 (Rs2D),
        .i_we  (RegWriteW),
        .i_wa  (RdW),
        .i_wd  (ResultW),
        .o_rd1 (RD1),
        .o_rd2 (RD2)
    );

endmodule
